signal_debouncer: RTL and testbench

SIGNAL_DEBOUNCER -- requirements
Module: signal_debouncer

---
 rtl/signal_debouncer.sv | 111 +++++++++++
 tb/tb_signal_debouncer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/signal_debouncer.sv
// Two-flop (or deeper) synchronizer followed by a four-state debounce FSM.
// Emits a clean registered level plus a saturating count of rejected candidate changes.
module signal_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                async_in,
    output logic                signal_out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [GLITCH_W-1:0]    glitch_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Rejected candidates are counted but the counter sticks at all-ones.
    assign glitch_d = (glitch_count == '1) ? glitch_count : glitch_count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= STABLE_LOW;
            cnt_q        <= '0;
            signal_out   <= 1'b0;
            busy         <= 1'b0;
            glitch_count <= '0;
        end else begin
            case (state_q)
                STABLE_LOW: begin
                    if (s) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_W'(1);
                        busy    <= 1'b1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state_q      <= STABLE_LOW;
                        cnt_q        <= '0;
                        busy         <= 1'b0;
                        glitch_count <= glitch_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= STABLE_HIGH;
                        cnt_q      <= '0;
                        busy       <= 1'b0;
                        signal_out <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_W'(1);
                        busy    <= 1'b1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state_q      <= STABLE_HIGH;
                        cnt_q        <= '0;
                        busy         <= 1'b0;
                        glitch_count <= glitch_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= STABLE_LOW;
                        cnt_q      <= '0;
                        busy       <= 1'b0;
                        signal_out <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= STABLE_LOW;
                    cnt_q   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signal_debouncer.sv
// Bench for signal_debouncer: directed scenarios plus random pulse trains, checked every
// cycle against a run-length reference model (default DUT and a GLITCH_W=2 DUT side by side).
module tb_signal_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b1;
    logic       rst = 1'b0;
    logic       async_in = 1'b0;
    logic       signal_out_a, busy_a, signal_out_b, busy_b;
    logic [7:0] gc_a;
    logic [1:0] gc_b;

    int n_checks = 0;
    int n_pass   = 0;

    signal_debouncer dut_a (
        .clk(clk), .rst(rst), .async_in(async_in),
        .signal_out(signal_out_a), .busy(busy_a), .glitch_count(gc_a)
    );

    signal_debouncer #(.GLITCH_W(2)) dut_b (
        .clk(clk), .rst(rst), .async_in(async_in),
        .signal_out(signal_out_b), .busy(busy_b), .glitch_count(gc_b)
    );

    always #5 clk = ~clk;

    // Reference: the level seen SYNC edges late must differ from the output for DEB
    // consecutive edges to flip it; any shorter run that ends is one glitch.
    logic [SYNC-1:0] pipe_m   = '0;
    logic            out_m    = 1'b0;
    int              run_m    = 0;
    int              glitch_m = 0;
    logic            s_seen;
    assign s_seen = pipe_m[SYNC-1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_m   <= '0;
            out_m    <= 1'b0;
            run_m    <= 0;
            glitch_m <= 0;
        end else begin
            pipe_m <= {pipe_m[SYNC-2:0], async_in};
            if (s_seen != out_m) begin
                if (run_m + 1 == DEB) begin
                    out_m <= ~out_m;
                    run_m <= 0;
                end else begin
                    run_m <= run_m + 1;
                end
            end else begin
                if (run_m != 0) glitch_m <= glitch_m + 1;
                run_m <= 0;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        check("out_a", int'(signal_out_a), int'(out_m));
        check("busy_a", int'(busy_a), (run_m != 0) ? 1 : 0);
        check("gc_a", int'(gc_a), (glitch_m > 255) ? 255 : glitch_m);
        check("out_b", int'(signal_out_b), int'(out_m));
        check("busy_b", int'(busy_b), (run_m != 0) ? 1 : 0);
        check("gc_b", int'(gc_b), (glitch_m > 3) ? 3 : glitch_m);
    end

    task automatic check_zero(input string tag);
        check({tag, "_out"}, int'(signal_out_a), 0);
        check({tag, "_busy"}, int'(busy_a), 0);
        check({tag, "_gc"}, int'(gc_a), 0);
        check({tag, "_gcb"}, int'(gc_b), 0);
    endtask

    // Called at a falling edge; asserts reset mid-cycle and releases it mid-cycle.
    task automatic pulse_rst(input int cycles);
        #2 rst = 1'b1;
        #1 check_zero("rst_now");
        repeat (cycles) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a falling edge; holds the level for exactly n rising edges.
    task automatic hold(input logic v, input int n);
        async_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Counts rising edges until signal_out_a goes high (0 if never within bound).
    task automatic wait_rise(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (signal_out_a) begin
                n = i;
                break;
            end
        end
        @(negedge clk);
    endtask

    int lat;
    int rises;
    int sat_exp [5];

    initial begin
        sat_exp = '{1, 2, 3, 3, 3};

        // Reset from time 0, released at 25 (a falling edge)
        #1 rst = 1'b1;
        #1 check_zero("rst_init");
        #23 rst = 1'b0;
        repeat (10) @(negedge clk);
        check_zero("post_rst");
        $display("reset: released, outputs idle");

        // Clean rise latency
        async_in = 1'b1;
        wait_rise(lat);
        check("rise_latency", lat, SYNC + DEB);
        hold(1'b1, 34);
        check("rise_gc", int'(gc_a), 0);
        hold(1'b0, 10);
        check("fall_out", int'(signal_out_a), 0);
        $display("clean rise: latency %0d edges", lat);

        // Two-edge glitch
        pulse_rst(1);
        hold(1'b1, 2);
        hold(1'b0, 8);
        check("glitch_out", int'(signal_out_a), 0);
        check("glitch_gc", int'(gc_a), 1);
        check("glitch_busy", int'(busy_a), 0);
        $display("glitch: count %0d", gc_a);

        // DEB-1 edges rejected, exactly DEB edges accepted
        pulse_rst(1);
        hold(1'b1, DEB - 1);
        hold(1'b0, 8);
        rises = 0;
        async_in = 1'b1;
        for (int i = 0; i < 14; i++) begin
            logic prev;
            prev = signal_out_a;
            if (i == DEB) async_in = 1'b0;
            @(negedge clk);
            if (signal_out_a && !prev) rises++;
        end
        check("bound_rises", rises, 1);
        check("bound_gc", int'(gc_a), 1);
        check("bound_out", int'(signal_out_a), 0);
        $display("boundary: rises %0d count %0d", rises, gc_a);

        // Saturation on the narrow counter
        pulse_rst(1);
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 2);
            hold(1'b0, 8);
            check("sat_gcb", int'(gc_b), sat_exp[i]);
            $display("saturation: glitch %0d count_b %0d", i + 1, gc_b);
        end

        // Reset during qualification
        pulse_rst(1);
        hold(1'b1, 3);
        check("midrst_busy", int'(busy_a), 1);
        #2 rst = 1'b1;
        #1 check_zero("midrst_now");
        @(negedge clk);
        #2 rst = 1'b0;
        wait_rise(lat);
        check("midrst_latency", lat, SYNC + DEB);
        check("midrst_gc", int'(gc_a), 0);
        hold(1'b0, 10);
        $display("mid-op reset: latency %0d edges", lat);

        // Random pulse trains around the qualification boundary
        for (int seg = 0; seg < 300; seg++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 39) == 0) begin
                pulse_rst(1);
                $display("seg %0d: reset", seg);
            end
            hold(lvl, len);
            $display("seg %0d: level %0d for %0d edges, out %0d count %0d", seg, lvl, len, signal_out_a, gc_a);
        end
        hold(1'b0, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
